i2s_rx: RTL and testbench

- Serial audio front end for the FM transmitter. Oversamples an external I2S/left-justified link on the system clock and extracts one channel as an A-bit two's-complement sample.
- Its output feeds the audio input of the FM modulator.
- Its mode inputs are driven by the i2s_ws_align and audio_chan_sel outputs of the configuration block.
- Used when usb_i2sn = 0.

---
 rtl/i2s_rx.sv | 167 ++++++++++++++++
 tb/tb_i2s_rx.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_rx.sv
// I2S / left-justified serial audio receiver: oversamples the link on clk and extracts one channel.
// Optional BCK-loss timeout is compiled in when I2S_RX_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module i2s_rx #(
  parameter int unsigned A       = 8,
  parameter int unsigned W       = 32,
  parameter int unsigned TO_BITS = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i2s_bck,
  input  logic         i2s_ws,
  input  logic         i2s_sd,
  input  logic         i2s_ws_align,
  input  logic         audio_chan_sel,
  output logic [A-1:0] audio,
  output logic         audio_valid,
  output logic         i2s_active
);

  localparam int unsigned   CW      = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(W - 1);

  if (A < 2 || A > W || TO_BITS < 2) begin : g_param_check
    $error("i2s_rx: parameters out of range");
  end

  logic          bck_s1_q, bck_s2_q, bck_s3_q;
  logic          ws_s1_q, ws_s2_q;
  logic          sd_s1_q, sd_s2_q;
  logic [A-1:0]  sh_q, sh_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ws_prev_q, ws_prev_d;
  logic          synced_q, synced_d;
  logic          close_q, close_d;
  logic [A-1:0]  close_data_q, close_data_d;
  logic [A-1:0]  audio_q, audio_d;
  logic          valid_q, valid_d;

  logic          bck_rise;
  logic          ws_chg;
  logic [A-1:0]  sh_acc;
  logic [CW-1:0] cnt_acc;

`ifdef I2S_RX_TIMEOUT_EN
  localparam logic [TO_BITS-1:0] TO_MAX = '1;
  logic [TO_BITS-1:0] to_cnt_q, to_cnt_d;
  logic               to_fire_q, to_fire_d;
`endif

  // Short slots are padded with zero LSBs so the MSB always lands in audio[A-1].
  function automatic logic [A-1:0] left_justify(input logic [A-1:0] d, input logic [CW-1:0] n);
    logic [A-1:0] r;
    if (32'(n) >= A) r = d;
    else             r = d << (A - 32'(n));
    return r;
  endfunction

  assign bck_rise = bck_s2_q & ~bck_s3_q;
  assign ws_chg   = bck_rise & (ws_s2_q != ws_prev_q);
  assign sh_acc   = (32'(cnt_q) < A) ? {sh_q[A-2:0], sd_s2_q} : sh_q;
  assign cnt_acc  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    sh_d         = sh_q;
    cnt_d        = cnt_q;
    ws_prev_d    = ws_prev_q;
    synced_d     = synced_q;
    close_d      = 1'b0;
    close_data_d = close_data_q;
    if (bck_rise) begin
      ws_prev_d = ws_s2_q;
      if (ws_chg) begin
        synced_d = 1'b1;
        close_d  = synced_q & (ws_prev_q == audio_chan_sel);
        // Alignment only matters at a slot boundary, so sampling it here makes mid-slot changes inert.
        if (i2s_ws_align) begin
          close_data_d = left_justify(sh_q, cnt_q);
          sh_d         = A'(sd_s2_q);
          cnt_d        = CW'(1);
        end else begin
          close_data_d = left_justify(sh_acc, cnt_acc);
          sh_d         = '0;
          cnt_d        = '0;
        end
      end else begin
        sh_d  = sh_acc;
        cnt_d = cnt_acc;
      end
    end

    audio_d = close_q ? close_data_q : audio_q;
    valid_d = close_q;
`ifdef I2S_RX_TIMEOUT_EN
    if (to_fire_q) begin
      synced_d = 1'b0;
      audio_d  = '0;
      valid_d  = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bck_s1_q     <= 1'b0;
      bck_s2_q     <= 1'b0;
      bck_s3_q     <= 1'b0;
      ws_s1_q      <= 1'b0;
      ws_s2_q      <= 1'b0;
      sd_s1_q      <= 1'b0;
      sd_s2_q      <= 1'b0;
      sh_q         <= '0;
      cnt_q        <= '0;
      ws_prev_q    <= 1'b0;
      synced_q     <= 1'b0;
      close_q      <= 1'b0;
      close_data_q <= '0;
      audio_q      <= '0;
      valid_q      <= 1'b0;
    end else begin
      bck_s1_q     <= i2s_bck;
      bck_s2_q     <= bck_s1_q;
      bck_s3_q     <= bck_s2_q;
      ws_s1_q      <= i2s_ws;
      ws_s2_q      <= ws_s1_q;
      sd_s1_q      <= i2s_sd;
      sd_s2_q      <= sd_s1_q;
      sh_q         <= sh_d;
      cnt_q        <= cnt_d;
      ws_prev_q    <= ws_prev_d;
      synced_q     <= synced_d;
      close_q      <= close_d;
      close_data_q <= close_data_d;
      audio_q      <= audio_d;
      valid_q      <= valid_d;
    end
  end

`ifdef I2S_RX_TIMEOUT_EN
  // Counter parks at TO_MAX so a stopped link produces a single silence strobe.
  always_comb begin
    to_cnt_d  = to_cnt_q;
    to_fire_d = 1'b0;
    if (bck_rise) begin
      to_cnt_d = '0;
    end else if (to_cnt_q != TO_MAX) begin
      to_cnt_d  = to_cnt_q + 1'b1;
      to_fire_d = (to_cnt_q == TO_MAX - 1'b1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt_q  <= '0;
      to_fire_q <= 1'b0;
    end else begin
      to_cnt_q  <= to_cnt_d;
      to_fire_q <= to_fire_d;
    end
  end
`endif

  assign audio       = audio_q;
  assign audio_valid = valid_q;
  assign i2s_active  = synced_q;

endmodule

// File: tb/tb_i2s_rx.sv
// Self-checking bench for i2s_rx: bit-level link driver, slot-level expectation model, strobe scoreboard.
`timescale 1ns/1ps
module tb_i2s_rx;
  localparam int A = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic i2s_bck = 1'b0;
  logic i2s_ws = 1'b0;
  logic i2s_sd = 1'b0;
  logic i2s_ws_align = 1'b0;
  logic audio_chan_sel = 1'b0;
  logic [A-1:0] audio;
  logic audio_valid;
  logic i2s_active;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [A-1:0] exp_q[$];
  int stamp_q[$];
  int lat_q[$];
  bit m_synced;
  bit m_prev;
  int last_rise;
  logic [A-1:0] last_exp;

  i2s_rx #(.A(8), .W(32), .TO_BITS(10)) dut (
    .clk(clk),
    .rst(rst),
    .i2s_bck(i2s_bck),
    .i2s_ws(i2s_ws),
    .i2s_sd(i2s_sd),
    .i2s_ws_align(i2s_ws_align),
    .audio_chan_sel(audio_chan_sel),
    .audio(audio),
    .audio_valid(audio_valid),
    .i2s_active(i2s_active)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Top A bits of an nb-bit slot, zero-padded when the slot is shorter than A.
  function automatic logic [A-1:0] top_bits(input logic [31:0] d, input int nb);
    logic [63:0] t;
    t = 64'(d) & ((64'd1 << nb) - 64'd1);
    if (nb >= A) return A'(t >> (nb - A));
    return A'(t << (A - nb));
  endfunction

  task automatic push_exp(input logic [A-1:0] v, input int stamp, input int lat);
    exp_q.push_back(v);
    stamp_q.push_back(stamp);
    lat_q.push_back(lat);
    last_exp = v;
  endtask

  task automatic monitor();
    logic [A-1:0] e;
    int s;
    int l;
    forever begin
      @(negedge clk);
      if (audio_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_strobe: audio=%h at cycle %0d, required no strobe", audio, cyc);
        end else begin
          e = exp_q.pop_front();
          s = stamp_q.pop_front();
          l = lat_q.pop_front();
          if (audio !== e) begin
            errors++;
            $display("FAIL sample: audio=%h required=%h", audio, e);
          end
          checks++;
          if (cyc - s != l) begin
            errors++;
            $display("FAIL latency: got %0d clk required %0d clk", cyc - s, l);
          end
        end
      end
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) begin
      i2s_bck = 1'($urandom_range(0, 1));
      i2s_ws  = 1'($urandom_range(0, 1));
      i2s_sd  = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    i2s_bck = 1'b0;
    i2s_ws  = 1'b0;
    i2s_sd  = 1'b0;
    rst     = 1'b0;
    m_synced = 1'b0;
    m_prev   = 1'b0;
    exp_q.delete();
    stamp_q.delete();
    lat_q.delete();
  endtask

  // Drives frames of L/R slots, BCK = clk/8. i2s_std delays sd one bit behind ws (standard I2S);
  // skew models an align=1 receiver fed a standard stream. rst_at >= 0 pulses rst at that bit.
  task automatic play(input bit i2s_std, input bit skew, input int nb,
                      input logic [31:0] l, input logic [31:0] r, input int frames,
                      input int rst_at, input bit toggle);
    logic lj_ws[$];
    logic lj_sd[$];
    logic [31:0] d;
    logic [31:0] o;
    logic ws_b, sd_b, prev_lj_sd;
    int n;
    for (int f = 0; f < frames; f++) begin
      for (int c = 0; c < 2; c++) begin
        d = (c == 1) ? r : l;
        for (int i = nb - 1; i >= 0; i--) begin
          lj_ws.push_back(c == 1);
          lj_sd.push_back(d[i]);
        end
      end
    end
    lj_ws.push_back(1'b0);
    lj_sd.push_back(1'b0);
    prev_lj_sd = 1'b0;
    n = lj_ws.size();
    for (int k = 0; k < n; k++) begin
      ws_b = lj_ws[k];
      sd_b = i2s_std ? prev_lj_sd : lj_sd[k];
      prev_lj_sd = lj_sd[k];
      i2s_bck = 1'b0;
      i2s_ws  = ws_b;
      i2s_sd  = sd_b;
      if (toggle && (k % nb == nb / 2 || k % nb == nb / 2 + 2)) i2s_ws_align = ~i2s_ws_align;
      if (k == rst_at) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_synced = 1'b0;
        m_prev   = 1'b0;
        checks++;
        if (audio !== '0) begin
          errors++;
          $display("FAIL midreset_audio: audio=%h required=00", audio);
        end
        checks++;
        if (audio_valid !== 1'b0) begin
          errors++;
          $display("FAIL midreset_valid: audio_valid=%b required=0", audio_valid);
        end
        checks++;
        if (i2s_active !== 1'b0) begin
          errors++;
          $display("FAIL midreset_active: i2s_active=%b required=0", i2s_active);
        end
      end
      repeat (4) @(negedge clk);
      if (ws_b != m_prev) begin
        if (m_synced && m_prev == audio_chan_sel) begin
          d = m_prev ? r : l;
          o = m_prev ? l : r;
          if (skew) push_exp(top_bits((32'(o[0]) << (nb - 1)) | (d >> 1), nb), cyc, 4);
          else      push_exp(top_bits(d, nb), cyc, 4);
        end
        m_synced = 1'b1;
      end
      m_prev = ws_b;
      i2s_bck = 1'b1;
      last_rise = cyc;
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic drain(input string name);
    repeat (12) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_missing: %0d strobes outstanding, required 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    do_reset(3);
    checks++;
    if (audio !== '0) begin errors++; $display("FAIL reset_audio: audio=%h required=00", audio); end
    checks++;
    if (audio_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: audio_valid=%b required=0", audio_valid); end
    checks++;
    if (i2s_active !== 1'b0) begin errors++; $display("FAIL reset_active: i2s_active=%b required=0", i2s_active); end
    i2s_ws_align = 1'b0;
    audio_chan_sel = 1'b0;
    play(1'b1, 1'b0, 16, 32'h5A3C, 32'hC3A5, 3, -1, 1'b0);
    drain("reset");
    checks++;
    if (i2s_active !== 1'b1) begin errors++; $display("FAIL active_set: i2s_active=%b required=1", i2s_active); end
  endtask

  task automatic test_mode0();
    do_reset(2);
    i2s_ws_align = 1'b0;
    audio_chan_sel = 1'b1;
    play(1'b1, 1'b0, 16, 32'h5A3C, 32'hC3A5, 3, -1, 1'b0);
    drain("mode0_right");
  endtask

  task automatic test_mode1();
    do_reset(2);
    i2s_ws_align = 1'b1;
    audio_chan_sel = 1'b0;
    play(1'b0, 1'b0, 16, 32'h5A3C, 32'hC3A5, 2, -1, 1'b0);
    drain("mode1_left");
    do_reset(2);
    audio_chan_sel = 1'b1;
    play(1'b0, 1'b0, 16, 32'h5A3C, 32'hC3A5, 2, -1, 1'b0);
    drain("mode1_right");
    do_reset(2);
    audio_chan_sel = 1'b0;
    play(1'b1, 1'b1, 16, 32'h5A3C, 32'hC3A5, 2, -1, 1'b0);
    drain("mode_mismatch");
    do_reset(2);
    i2s_ws_align = 1'b0;
    play(1'b1, 1'b0, 16, 32'h5A3C, 32'hC3A5, 3, -1, 1'b1);
    drain("mode_latch");
  endtask

  task automatic test_slot_len();
    do_reset(2);
    i2s_ws_align = 1'b0;
    audio_chan_sel = 1'b0;
    play(1'b1, 1'b0, 6, 32'h2D, 32'h13, 3, -1, 1'b0);
    drain("short_left");
    do_reset(2);
    audio_chan_sel = 1'b1;
    play(1'b1, 1'b0, 6, 32'h2D, 32'h13, 3, -1, 1'b0);
    drain("short_right");
    do_reset(2);
    audio_chan_sel = 1'b0;
    play(1'b1, 1'b0, 32, 32'h5A3CF00F, 32'hC3A51234, 3, -1, 1'b0);
    drain("long_slot");
  endtask

  task automatic test_mid_reset();
    do_reset(2);
    i2s_ws_align = 1'b0;
    audio_chan_sel = 1'b0;
    play(1'b1, 1'b0, 16, 32'h5A3C, 32'hC3A5, 4, 69, 1'b0);
    drain("mid_reset");
  endtask

  task automatic test_bck_stop();
    do_reset(2);
    i2s_ws_align = 1'b0;
    audio_chan_sel = 1'b1;
    play(1'b1, 1'b0, 16, 32'h5A3C, 32'hC3A5, 2, -1, 1'b0);
`ifdef I2S_RX_TIMEOUT_EN
    push_exp('0, last_rise, 1027);
    repeat (1100) @(negedge clk);
    checks++;
    if (i2s_active !== 1'b0) begin errors++; $display("FAIL timeout_active: i2s_active=%b required=0", i2s_active); end
    m_synced = 1'b0;
    audio_chan_sel = 1'b0;
    play(1'b1, 1'b0, 16, 32'h5A3C, 32'hC3A5, 2, -1, 1'b0);
    drain("timeout_resume");
`else
    repeat (1100) @(negedge clk);
    checks++;
    if (audio !== last_exp) begin errors++; $display("FAIL hold_audio: audio=%h required=%h", audio, last_exp); end
    checks++;
    if (i2s_active !== 1'b1) begin errors++; $display("FAIL hold_active: i2s_active=%b required=1", i2s_active); end
    drain("hold");
`endif
  endtask

  initial begin
    fork
      monitor();
      begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1);
      end
    join_none
    @(negedge clk);
    test_reset();
    test_mode0();
    test_mode1();
    test_slot_len();
    test_mid_reset();
    test_bck_stop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
